// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI bridge tag directory.
// Holds the slot state enum, the directory and completion payloads, the
// DIR_ST_* result codes and the AXI response codes.
package apb2axi_pkg;

    localparam int unsigned DIR_TAG_W  = 6;   // fits the largest supported directory (64)
    localparam int unsigned DIR_ADDR_W = 32;
    localparam int unsigned DIR_BEAT_W = 8;

    localparam logic [1:0] DIR_ST_IDLE  = 2'd0;
    localparam logic [1:0] DIR_ST_DONE  = 2'd1;
    localparam logic [1:0] DIR_ST_ERROR = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ENTRY_EMPTY     = 2'd0,
        ENTRY_ALLOCATED = 2'd1,
        ENTRY_PENDING   = 2'd2,
        ENTRY_COMPLETE  = 2'd3
    } entry_state_e;

    typedef struct packed {
        logic [DIR_TAG_W-1:0]  tag;
        logic                  is_write;
        logic [DIR_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [DIR_BEAT_W-1:0] len;
        logic [1:0]            resp;
        logic [DIR_BEAT_W-1:0] num_beats;
        logic [DIR_BEAT_W-1:0] err_beat_idx;
        logic [1:0]            state;
    } directory_entry_t;

    typedef struct packed {
        logic [DIR_TAG_W-1:0]  tag;
        logic [1:0]            resp;
        logic [DIR_BEAT_W-1:0] num_beats;
        logic [DIR_BEAT_W-1:0] err_beat_idx;
        logic                  error;
    } completion_entry_t;

endpackage

// File: rtl/apb2axi_age_matrix.sv
// Allocation-order tracker for the tag directory.
// older[i][j] = 1 means slot i was allocated before slot j.
// Ports: pclk/preset (async active-high), alloc_en/alloc_idx mark a new
// youngest slot, clr_mask drops slots from ordering, older exposes the matrix.
module apb2axi_age_matrix #(
    parameter int unsigned DIR_ENTRIES = 8,
    parameter int unsigned IDX_W       = $clog2(DIR_ENTRIES)
) (
    input  logic                                   pclk,
    input  logic                                   preset,
    input  logic                                   alloc_en,
    input  logic [IDX_W-1:0]                       alloc_idx,
    input  logic [DIR_ENTRIES-1:0]                 clr_mask,
    output logic [DIR_ENTRIES-1:0][DIR_ENTRIES-1:0] older
);

    logic [DIR_ENTRIES-1:0][DIR_ENTRIES-1:0] older_q;
    logic [DIR_ENTRIES-1:0][DIR_ENTRIES-1:0] older_d;

    // New slot is younger than every other; cleared slots leave the ordering.
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            for (int j = 0; j < DIR_ENTRIES; j++) begin
                if (alloc_en && (IDX_W'(j) == alloc_idx) && (i != j)) begin
                    older_d[i][j] = 1'b1;
                end
                if (alloc_en && (IDX_W'(i) == alloc_idx)) begin
                    older_d[i][j] = 1'b0;
                end
                if (clr_mask[i] || clr_mask[j]) begin
                    older_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    assign older = older_q;

endmodule

// File: rtl/apb2axi_tag_directory.sv
// Tag directory: tracks outstanding APB-to-AXI descriptors per TAG slot
// through EMPTY -> ALLOCATED -> PENDING -> COMPLETE -> EMPTY.
// Ports: alloc_* (descriptor intake), rd_pop_* / wr_pop_* (oldest ALLOCATED
// entry per direction), cpl_* (completions), consume_* (APB release),
// sel_* (inspection), free_cnt, illegal_cpl/illegal_clr, tmo_limit, tag_size.
// Optional: define APB2AXI_DIR_TIMEOUT_EN for per-slot PENDING timeouts.
module apb2axi_tag_directory
    import apb2axi_pkg::*;
#(
    parameter int unsigned DIR_ENTRIES = 8,
    parameter int unsigned TAG_W       = $clog2(DIR_ENTRIES),
    parameter int unsigned TMO_W       = 16
) (
    input  logic                              pclk,
    input  logic                              preset,
    input  logic                              alloc_vld,
    input  directory_entry_t                  alloc_entry,
    output logic                              alloc_rdy,
    output logic [TAG_W-1:0]                  alloc_tag,
    output logic                              rd_pop_vld,
    output directory_entry_t                  rd_pop_entry,
    input  logic                              rd_pop_rdy,
    output logic                              wr_pop_vld,
    output directory_entry_t                  wr_pop_entry,
    input  logic                              wr_pop_rdy,
    input  logic                              cpl_vld,
    input  completion_entry_t                 cpl_entry,
    output logic                              cpl_rdy,
    input  logic                              consume_vld,
    input  logic [TAG_W-1:0]                  consume_tag,
    input  logic [TAG_W-1:0]                  sel_tag,
    output directory_entry_t                  sel_entry,
    output entry_state_e                      sel_state,
    output logic [$clog2(DIR_ENTRIES+1)-1:0]  free_cnt,
    output logic                              illegal_cpl,
    input  logic                              illegal_clr,
    input  logic [TMO_W-1:0]                  tmo_limit,
    output logic [DIR_ENTRIES-1:0][2:0]       tag_size
);

    localparam int unsigned CNT_W = $clog2(DIR_ENTRIES + 1);

    entry_state_e     state_q [DIR_ENTRIES];
    entry_state_e     state_d [DIR_ENTRIES];
    directory_entry_t entry_q [DIR_ENTRIES];
    directory_entry_t entry_d [DIR_ENTRIES];

    logic [DIR_ENTRIES-1:0][DIR_ENTRIES-1:0] older;
    logic [DIR_ENTRIES-1:0] rd_cand, wr_cand, rd_oldest, wr_oldest;
    logic [DIR_ENTRIES-1:0] cpl_hit, tmo_hit, clr_mask;
    logic [TAG_W-1:0]       rd_idx, wr_idx;
    logic                   alloc_fire, rd_fire, wr_fire, consume_fire, illegal_set;

    // The offered tag is always replaced by the slot index.
    logic alloc_tag_unused;
    assign alloc_tag_unused = ^alloc_entry.tag;

    // Lowest-index EMPTY slot receives the next descriptor.
    always_comb begin
        alloc_tag = '0;
        for (int i = DIR_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ENTRY_EMPTY) alloc_tag = TAG_W'(i);
        end
    end

    assign alloc_rdy    = (free_cnt != '0);
    assign alloc_fire   = alloc_vld && alloc_rdy;
    assign consume_fire = consume_vld && (state_q[consume_tag] == ENTRY_COMPLETE);

    // Oldest ALLOCATED slot per direction: no older candidate of the same kind.
    always_comb begin
        rd_cand   = '0;
        wr_cand   = '0;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            rd_cand[i] = (state_q[i] == ENTRY_ALLOCATED) && !entry_q[i].is_write;
            wr_cand[i] = (state_q[i] == ENTRY_ALLOCATED) &&  entry_q[i].is_write;
        end
    end

    always_comb begin
        rd_oldest = rd_cand;
        wr_oldest = wr_cand;
        rd_idx    = '0;
        wr_idx    = '0;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            for (int j = 0; j < DIR_ENTRIES; j++) begin
                if (rd_cand[j] && older[j][i]) rd_oldest[i] = 1'b0;
                if (wr_cand[j] && older[j][i]) wr_oldest[i] = 1'b0;
            end
        end
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (rd_oldest[i]) rd_idx = TAG_W'(i);
            if (wr_oldest[i]) wr_idx = TAG_W'(i);
        end
    end

    assign rd_pop_vld   = |rd_oldest;
    assign wr_pop_vld   = |wr_oldest;
    assign rd_pop_entry = entry_q[rd_idx];
    assign wr_pop_entry = entry_q[wr_idx];
    assign rd_fire      = rd_pop_vld && rd_pop_rdy;
    assign wr_fire      = wr_pop_vld && wr_pop_rdy;

    always_comb begin
        cpl_hit = '0;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            cpl_hit[i] = cpl_vld && (state_q[i] == ENTRY_PENDING) &&
                         (cpl_entry.tag == DIR_TAG_W'(i));
        end
    end

    assign illegal_set = cpl_vld && !(|cpl_hit);

    assign clr_mask = (rd_fire      ? rd_oldest : '0) |
                      (wr_fire      ? wr_oldest : '0) |
                      (consume_fire ? (DIR_ENTRIES'(1) << consume_tag) : '0);

`ifdef APB2AXI_DIR_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q [DIR_ENTRIES];

    // Cycles spent PENDING; restarts whenever the slot is in any other state.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DIR_ENTRIES; i++) tmo_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                tmo_cnt_q[i] <= (state_q[i] == ENTRY_PENDING) ? tmo_cnt_q[i] + TMO_W'(1) : '0;
            end
        end
    end

    always_comb begin
        tmo_hit = '0;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            tmo_hit[i] = (state_q[i] == ENTRY_PENDING) && (tmo_limit != '0) &&
                         (tmo_cnt_q[i] >= tmo_limit - TMO_W'(1));
        end
    end
`else
    logic tmo_limit_unused;
    assign tmo_limit_unused = ^tmo_limit;
    assign tmo_hit          = '0;
`endif

    // Per-slot next state; each state accepts only its own advancing event.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            case (state_q[i])
                ENTRY_EMPTY: begin
                    if (alloc_fire && (alloc_tag == TAG_W'(i))) begin
                        state_d[i]     = ENTRY_ALLOCATED;
                        entry_d[i]     = alloc_entry;
                        entry_d[i].tag = DIR_TAG_W'(i);
                    end
                end
                ENTRY_ALLOCATED: begin
                    if ((rd_fire && rd_oldest[i]) || (wr_fire && wr_oldest[i])) begin
                        state_d[i] = ENTRY_PENDING;
                    end
                end
                ENTRY_PENDING: begin
                    if (cpl_hit[i]) begin
                        state_d[i]              = ENTRY_COMPLETE;
                        entry_d[i].resp         = cpl_entry.resp;
                        entry_d[i].num_beats    = cpl_entry.num_beats;
                        entry_d[i].err_beat_idx = cpl_entry.err_beat_idx;
                        entry_d[i].state        = cpl_entry.error ? DIR_ST_ERROR : DIR_ST_DONE;
                    end else if (tmo_hit[i]) begin
                        state_d[i]       = ENTRY_COMPLETE;
                        entry_d[i].resp  = AXI_RESP_SLVERR;
                        entry_d[i].state = DIR_ST_ERROR;
                    end
                end
                ENTRY_COMPLETE: begin
                    if (consume_fire && (consume_tag == TAG_W'(i))) begin
                        state_d[i] = ENTRY_EMPTY;
                        entry_d[i] = '0;
                    end
                end
                default: state_d[i] = ENTRY_EMPTY;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                state_q[i] <= ENTRY_EMPTY;
                entry_q[i] <= '0;
            end
            free_cnt    <= CNT_W'(DIR_ENTRIES);
            illegal_cpl <= 1'b0;
            cpl_rdy     <= 1'b1;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            free_cnt    <= free_cnt - CNT_W'(alloc_fire) + CNT_W'(consume_fire);
            illegal_cpl <= illegal_set ? 1'b1 : (illegal_clr ? 1'b0 : illegal_cpl);
            cpl_rdy     <= 1'b1;
        end
    end

    assign sel_entry = entry_q[sel_tag];
    assign sel_state = state_q[sel_tag];

    always_comb begin
        tag_size = '0;
        for (int i = 0; i < DIR_ENTRIES; i++) tag_size[i] = entry_q[i].size;
    end

    apb2axi_age_matrix #(
        .DIR_ENTRIES (DIR_ENTRIES),
        .IDX_W       (TAG_W)
    ) u_age (
        .pclk      (pclk),
        .preset    (preset),
        .alloc_en  (alloc_fire),
        .alloc_idx (alloc_tag),
        .clr_mask  (clr_mask),
        .older     (older)
    );

endmodule

// File: doc/apb2axi_tag_directory.md
APB2AXI_TAG_DIRECTORY -- requirements
Module: apb2axi_tag_directory

Interface
REQ-001 The block SHALL have parameter DIR_ENTRIES, default 8, giving the number of TAG slots (power of two, 2..64).
REQ-002 The block SHALL have parameter TAG_W, default $clog2(DIR_ENTRIES), giving the TAG width.
REQ-003 The block SHALL have parameter TMO_W, default 16, giving the timeout counter width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below.
- pclk  in  1  clock.
- preset  in  1  asynchronous, active-high reset.
- alloc_vld  in  1  new descriptor offered.
- alloc_entry  in  directory_entry_t  descriptor.
- alloc_rdy  out  1  free slot exists.
- alloc_tag  out  TAG_W  TAG the offered descriptor receives.
- rd_pop_vld / wr_pop_vld  out  1  oldest ALLOCATED read / write entry available.
- rd_pop_entry / wr_pop_entry  out  directory_entry_t  that entry.
- rd_pop_rdy / wr_pop_rdy  in  1  manager accepts.
- cpl_vld  in  1  completion offered.
- cpl_entry  in  completion_entry_t  completion.
- cpl_rdy  out  1  always 1 out of reset.
- consume_vld  in  1  APB consumed a TAG.
- consume_tag  in  TAG_W  that TAG.
- sel_tag  in  TAG_W  inspect index.
- sel_entry  out  directory_entry_t  combinational view.
- sel_state  out  entry_state_e  combinational view.
- free_cnt  out  $clog2(DIR_ENTRIES+1)  number of EMPTY slots.
- illegal_cpl  out  1  sticky protocol-error flag.
- illegal_clr  in  1  clears illegal_cpl.
- tmo_limit  in  TMO_W  PENDING timeout in cycles; 0 disables.
- tag_size  out  [DIR_ENTRIES][3]  size field per TAG.

Function
REQ-005 Each slot SHALL hold a state: EMPTY -> ALLOCATED (alloc handshake) -> PENDING (pop handshake) -> COMPLETE (completion) -> EMPTY (consume).
REQ-006 alloc_tag SHALL be the lowest-index EMPTY slot; alloc_rdy = (free_cnt != 0); on handshake the entry is stored with .tag overwritten by alloc_tag.
REQ-007 The rd and wr pop ports SHALL each present the ALLOCATED entry of their direction (is_write) that is oldest by allocation order, not by index; both ports may handshake in the same cycle.
REQ-008 On a completion for a PENDING TAG, the block SHALL store resp, num_beats, err_beat_idx and state DONE/ERROR from cpl_entry.error, and move the slot to COMPLETE next cycle.
REQ-009 A completion for a non-PENDING TAG SHALL be dropped and SHALL set illegal_cpl; illegal_clr clears it, and a set in the same cycle as a clear wins.
REQ-010 A consume SHALL act only if the slot was COMPLETE at the start of the cycle; otherwise it is ignored with no flag; a consumed slot is zeroed.
REQ-011 A slot freed in cycle N SHALL NOT be allocatable before cycle N+1; free_cnt SHALL be registered and reflect the net of alloc and consume in the same cycle.
REQ-012 A pop and a completion for the same TAG in the same cycle SHALL be treated per REQ-009 (the slot is still ALLOCATED).
REQ-013 Pop outputs SHALL be combinational from registered state, so pop latency is 0 and the state change is visible next cycle.

Reset
REQ-014 preset SHALL set all slots EMPTY with zeroed entries, age order empty, free_cnt=DIR_ENTRIES, illegal_cpl=0, cpl_rdy=1, and both pop_vld=0, including when asserted mid-transaction.

Configuration
REQ-015 With APB2AXI_DIR_TIMEOUT_EN defined, each PENDING slot SHALL count cycles and, on reaching tmo_limit (nonzero), go to COMPLETE with state=ERROR and resp=SLVERR; a real completion in the same cycle wins.
REQ-016 Without APB2AXI_DIR_TIMEOUT_EN, no counters SHALL exist and tmo_limit SHALL be ignored.

Structure
REQ-017 entry_state_e, directory_entry_t, completion_entry_t and the DIR_ST_* codes SHALL live in apb2axi_pkg.
REQ-018 Allocation-order tracking SHALL be a sub-module apb2axi_age_matrix (DIR_ENTRIES x DIR_ENTRIES older-than bits) with set-on-alloc and clear-on-pop/consume.

Verification
REQ-019 After reset, 8 allocs (reads) SHALL yield TAGs 0..7, then alloc_rdy=0 and free_cnt=0.
REQ-020 Alloc TAGs 0,1,2, consume TAG1 after completion, then allocate again: the new entry gets TAG1, and rd_pop SHALL present TAG0, then 2, then 1.
REQ-021 Mixed traffic W0,R1,W2 with both pop_rdy=1 SHALL pop TAG1 on rd and TAG0 on wr in the same cycle.
REQ-022 A completion to ALLOCATED TAG3 SHALL set illegal_cpl=1 with TAG3 unchanged; illegal_clr SHALL return it to 0.
REQ-023 With the macro defined and tmo_limit=10, a PENDING TAG0 with no completion SHALL be COMPLETE/ERROR/SLVERR 10 cycles after the pop.
REQ-024 Asserting preset while 4 TAGs are PENDING SHALL asynchronously give free_cnt=8 and all sel_state=EMPTY.
